// File: rtl/cmac_booth_pkg.sv
// cmac_booth_pkg: shared state encoding, Booth digit counts and datapath widths for the sequential Booth MAC.
package cmac_booth_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, ACC, OUT} state_e;
    localparam int BOOTH_DIG16 = 8;
    localparam int BOOTH_DIG8  = 4;
    localparam int PP16_W      = 17;
    localparam int PP8_W       = 9;
    localparam int PROD_W      = 33;
endpackage

// File: rtl/NV_NVDLA_CMAC_CORE_MAC_booth.sv
// NV_NVDLA_CMAC_CORE_MAC_booth: radix-4 Booth partial-product selector; out_data carries an inverted sign bit and out_inv the +1 of a negation.
module NV_NVDLA_CMAC_CORE_MAC_booth (
    input  logic [2:0]  code,
    input  logic        is_8bit,
    input  logic        sign,
    input  logic [15:0] src_data,
    output logic [16:0] out_data,
    output logic        out_inv
);
    logic        one;
    logic        two;
    logic        neg;
    logic [16:0] mag;
    logic [16:0] raw;
    always_comb begin
        one      = code[0] ^ code[1];
        two      = (code == 3'b011) || (code == 3'b100);
        neg      = (code[2] ^ sign) && (one || two);
        mag      = is_8bit ? {8'd0, two ? {src_data[7:0], 1'b0} : one ? {src_data[7], src_data[7:0]} : 9'd0}
                           : two ? {src_data, 1'b0} : one ? {src_data[15], src_data} : 17'd0;
        raw      = neg ? ~mag : mag;
        out_data = is_8bit ? {8'd0, ~raw[8], raw[7:0]} : {~raw[16], raw[15:0]};
        out_inv  = neg;
    end
endmodule

// File: rtl/cmac_booth_seq_mac.sv
// cmac_booth_seq_mac: one Booth digit per cycle into a product register, products summed into a group accumulator
// and emitted over valid/ready when the group's last op completes.
module cmac_booth_seq_mac
    import cmac_booth_pkg::*;
#(
    parameter int ACC_W = 40
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic             in_is_8bit,
    input  logic             in_neg,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum
);
    state_e              state_q, state_d;
    logic [15:0]         a_q, a_d, b_q, b_d;
    logic                is8_q, is8_d, neg_q, neg_d, last_q, last_d;
    logic [2:0]          i_q, i_d;
    logic [PROD_W-1:0]   p_q, p_d, pp;
    logic [ACC_W-1:0]    acc_q, acc_d, sum_q, sum_d, acc_new;
    logic [16:0]         b_ext;
    logic [2:0]          code;
    logic [16:0]         sel_data;
    logic                sel_inv;
    logic [PP16_W-1:0]   raw16;
    logic [PP8_W-1:0]    raw8;

    NV_NVDLA_CMAC_CORE_MAC_booth u_booth (
        .code     (code),
        .is_8bit  (is8_q),
        .sign     (neg_q),
        .src_data (a_q),
        .out_data (sel_data),
        .out_inv  (sel_inv)
    );

    // The +1 of a negation is applied after widening so -2 * -32768 (and -2 * -128) stays exact.
    always_comb begin
        b_ext   = {b_q, 1'b0};
        code    = b_ext[{i_q, 1'b0} +: 3];
        raw16   = {~sel_data[16], sel_data[15:0]};
        raw8    = {~sel_data[8], sel_data[7:0]};
        pp      = (is8_q ? {{(PROD_W-PP8_W){raw8[PP8_W-1]}}, raw8}
                         : {{(PROD_W-PP16_W){raw16[PP16_W-1]}}, raw16}) + {{(PROD_W-1){1'b0}}, sel_inv};
        acc_new = acc_q + {{(ACC_W-PROD_W){p_q[PROD_W-1]}}, p_q};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        is8_d   = is8_q;
        neg_d   = neg_q;
        last_d  = last_q;
        i_d     = i_q;
        p_d     = p_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = in_a;
                b_d     = in_b;
                is8_d   = in_is_8bit;
                neg_d   = in_neg;
                last_d  = in_last;
                i_d     = 3'd0;
                p_d     = '0;
                state_d = BUSY;
            end
            BUSY: begin
                p_d = p_q + (pp << {i_q, 1'b0});
                i_d = i_q + 3'd1;
                if (i_q == 3'(is8_q ? BOOTH_DIG8 - 1 : BOOTH_DIG16 - 1)) state_d = ACC;
            end
            ACC: begin
                acc_d   = last_q ? '0 : acc_new;
                sum_d   = last_q ? acc_new : sum_q;
                state_d = last_q ? OUT : IDLE;
            end
            OUT: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            is8_q   <= 1'b0;
            neg_q   <= 1'b0;
            last_q  <= 1'b0;
            i_q     <= '0;
            p_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            is8_q   <= is8_d;
            neg_q   <= neg_d;
            last_q  <= last_d;
            i_q     <= i_d;
            p_q     <= p_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign out_sum   = sum_q;
endmodule

// File: tb/tb_cmac_booth_seq_mac.sv
// tb_cmac_booth_seq_mac: directed vectors with hand-computed products and latencies for the sequential Booth MAC.
module tb_cmac_booth_seq_mac;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_is_8bit = 1'b0;
    logic        in_neg = 1'b0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [39:0] out_sum;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    cmac_booth_seq_mac #(.ACC_W(40)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_is_8bit     (in_is_8bit),
        .in_neg         (in_neg),
        .in_last        (in_last),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_sum        (out_sum)
    );

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic is8, input logic neg, input logic last);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL ready_wait: in_ready=%b required 1 within 50 cycles", in_ready);
            miscompares++;
        end
        in_a = a; in_b = b; in_is_8bit = is8; in_neg = neg; in_last = last; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b0) begin
            $display("FAIL busy_not_ready: in_ready=%b required 0", in_ready);
            miscompares++;
        end
    endtask

    // Counts the accept edge as cycle 1; called right after send.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL out_timeout: out_valid=%b required 1 within 40 cycles", out_valid);
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic check_sum(input string name, input logic [39:0] exp);
        vectors++;
        if (out_sum !== exp) begin
            $display("FAIL %s: out_sum=%0d (0x%h) required %0d (0x%h)", name, $signed(out_sum), out_sum, $signed(exp), exp);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors += 3;
        if (in_ready !== 1'b1) begin $display("FAIL rst_in_ready: got %b required 1", in_ready); miscompares++; end
        if (out_valid !== 1'b0) begin $display("FAIL rst_out_valid: got %b required 0", out_valid); miscompares++; end
        if (out_sum !== 40'd0) begin $display("FAIL rst_out_sum: got 0x%h required 0", out_sum); miscompares++; end
        #3 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic16();
        int lat;
        send(16'd3, 16'd5, 1'b0, 1'b0, 1'b1);
        wait_out(lat);
        vectors++;
        if (lat !== 10) begin $display("FAIL lat16: latency=%0d required 10", lat); miscompares++; end
        check_sum("mul_3x5", 40'd15);
        take();
    endtask

    task automatic test_extremes();
        int lat;
        send(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1);
        wait_out(lat);
        check_sum("min_x_min", 40'h0040000000);
        take();
        send(16'h8000, 16'hFFFF, 1'b0, 1'b1, 1'b1);
        wait_out(lat);
        check_sum("min_x_m1_neg", 40'hFFFFFF8000);
        take();
    endtask

    task automatic test_8bit();
        int lat;
        send(16'hFF80, 16'hFF7F, 1'b1, 1'b1, 1'b1);
        wait_out(lat);
        vectors++;
        if (lat !== 6) begin $display("FAIL lat8: latency=%0d required 6", lat); miscompares++; end
        check_sum("m128x127_neg", 40'd16256);
        take();
    endtask

    task automatic test_group();
        int lat;
        int early = 0;
        send(16'd7, 16'hFFF7, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 12; c++) begin
            if (out_valid) early++;
            @(posedge clk); #1;
        end
        send(16'd100, 16'd100, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 12; c++) begin
            if (out_valid) early++;
            @(posedge clk); #1;
        end
        vectors++;
        if (early !== 0) begin $display("FAIL group_early_valid: cycles_valid=%0d required 0", early); miscompares++; end
        send(16'hFFFE, 16'hFFFE, 1'b0, 1'b0, 1'b1);
        wait_out(lat);
        check_sum("group_sum", 40'hFFFFFFD8B5);
        take();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad = 0;
        send(16'd2, 16'd3, 1'b0, 1'b0, 1'b1);
        wait_out(lat);
        in_a = 16'd50; in_b = 16'd50; in_last = 1'b1; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (out_sum !== 40'd6 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        in_valid = 1'b0;
        vectors++;
        if (bad !== 0) begin $display("FAIL backpressure_hold: bad_cycles=%0d required 0", bad); miscompares++; end
        take();
        send(16'd1, 16'd1, 1'b0, 1'b0, 1'b1);
        wait_out(lat);
        check_sum("acc_restart", 40'd1);
        take();
        send(16'd1234, 16'd0, 1'b0, 1'b0, 1'b1);
        wait_out(lat);
        check_sum("zero_mult", 40'd0);
        take();
    endtask

    task automatic test_reset_mid();
        int lat;
        send(16'd5, 16'd5, 1'b0, 1'b0, 1'b0);
        send(16'd4, 16'd4, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin $display("FAIL rst_busy_ready: in_ready=%b required 1", in_ready); miscompares++; end
        #2 rst = 1'b0;
        send(16'd9, 16'd9, 1'b0, 1'b0, 1'b1);
        wait_out(lat);
        #2 rst = 1'b1;
        #1;
        vectors += 2;
        if (out_valid !== 1'b0) begin $display("FAIL rst_out_drop: out_valid=%b required 0", out_valid); miscompares++; end
        if (out_sum !== 40'd0) begin $display("FAIL rst_out_sum_clear: out_sum=0x%h required 0", out_sum); miscompares++; end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (in_ready !== 1'b1) begin $display("FAIL rst_release_ready: in_ready=%b required 1", in_ready); miscompares++; end
        send(16'd4, 16'd4, 1'b0, 1'b0, 1'b1);
        wait_out(lat);
        check_sum("after_reset", 40'd16);
        take();
    endtask

    initial begin
        test_reset();
        test_basic16();
        test_extremes();
        test_8bit();
        test_group();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cmac_booth_seq_mac.md
# cmac_booth_seq_mac

Sequential radix-4 Booth multiply-accumulate stage for the CMAC core. It wraps the existing Booth partial-product selector, NV_NVDLA_CMAC_CORE_MAC_booth. Each cycle it generates one Booth digit code from the multiplier, feeds it to the selector, reconstructs the signed partial product from the selector output, and sums it into a product register. Completed products are added to a running accumulator, which is emitted over a valid/ready handshake at the end of each accumulation group.

## Interface
- ACC_W, default 40: accumulator and output width (at least 34).
- nvdla_core_clk  input  1  core clock; all state updates on the rising edge.
- nvdla_core_rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  high only in IDLE; the operation is accepted when in_valid && in_ready.
- in_a  input  16  multiplicand, two's complement; only [7:0] used in 8-bit mode.
- in_b  input  16  multiplier, two's complement; only [7:0] used in 8-bit mode.
- in_is_8bit  input  1  precision select, latched at accept.
- in_neg  input  1  product negate (drives selector sign), latched at accept.
- in_last  input  1  this operation closes the accumulation group.
- out_valid  output  1  accumulator result available.
- out_ready  input  1  downstream accepts.
- out_sum  output  ACC_W  accumulated result, two's complement.

## Operation
- States: IDLE, BUSY, ACC, OUT.
- On accept, latch a, b, is_8bit, neg and last; set digit index i=0 and clear the product register P (33-bit signed); go to BUSY.
- Digit count: N=8 in 16-bit mode, N=4 in 8-bit mode.
- Digit code: {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
- BUSY cycle: the selector gets the code, is_8bit, sign=neg and src_data=a.
- 16-bit partial-product value: pp = {~out_data[16], out_data[15:0]} + out_inv, taken as 17-bit signed.
- 8-bit partial-product value: pp = {~out_data[8], out_data[7:0]} + out_inv, taken as 9-bit signed.
- BUSY update: P += sext(pp) << 2i, then i++. After digit N-1 go to ACC.
- ACC: acc += sext(P), wrapping modulo 2^ACC_W with no saturation.
  - If last: register the new acc into out_sum, clear acc, and go to OUT.
  - Otherwise go to IDLE.
- OUT: hold out_valid and a stable out_sum until out_ready, then go to IDLE.
- The result equals the sum over the group of (neg ? -a*b : a*b), signed, modulo 2^ACC_W.
- Reset values: state=IDLE, in_ready=1 (combinational from IDLE), out_valid=0, out_sum=0, acc=0, P=0, i=0.
- Boundary conditions:
  - b=0: every digit is the zero code, so P=0.
  - a=-32768 with digit +2 (or a=-128 in 8-bit mode) is exact within the pp width.
  - Group of one op with last=1: acc=0+P.
  - in_valid held during BUSY, ACC or OUT is not accepted, because in_ready=0.
- Reset asserted mid-operation discards the in-flight op, the accumulator and any pending result; out_valid falls immediately (asynchronously).

## Timing
- Accept at edge t. BUSY occupies edges t+1 through t+N, ACC is edge t+N+1.
- For a last op, out_valid is high from edge t+N+1 until the handshake edge.
- Latency from accept to out_valid: 10 cycles in 16-bit mode, 6 in 8-bit mode.
- in_ready rises after the ACC edge for a non-last op, and after the handshake edge for a last op.
- Minimum accept spacing: N+2 cycles.
- out_sum is stable from out_valid rise to handshake. No combinational path from in_* to out_*.

## Structure
- Shared package cmac_booth_pkg holds:
  - the state enum;
  - the N values (BOOTH_DIG16=8, BOOTH_DIG8=4);
  - the widths PP16_W=17, PP8_W=9, PROD_W=33.
- Sub-module: the existing NV_NVDLA_CMAC_CORE_MAC_booth, instanced once and used for every digit.
- Digit-code mux, pp reconstruction, shift and accumulate stay in this module.

## Test plan
- 16-bit, a=3, b=5, neg=0, last=1: out_valid exactly 10 cycles after accept; out_sum=15.
- 16-bit, a=-32768, b=-32768, last=1: out_sum=0x0040000000 (2^30). Same a with b=-1 and neg=1: out_sum=-32768.
- 8-bit, a=-128, b=127, neg=1, last=1: out_sum=16256; out_valid 6 cycles after accept; in_a[15:8] and in_b[15:8]=0xFF must be ignored.
- Group (7*-9, neg=0), (100*100, neg=1), (-2*-2, neg=0, last=1): out_sum=-10059; out_valid asserts only after the third op.
- Backpressure:
  - hold out_ready=0 for 5 cycles: out_sum stable and in_ready=0 throughout;
  - the next group starts from acc=0.
  - Zero-multiplier op (b=0, last=1) gives 0.
- Reset pulse in BUSY and again in OUT: out_valid drops immediately, in_ready=1 after release, and the next op (4*4, last=1) returns 16.
